// File: rtl/fxp_qaddsub_mc.sv
// fxp_qaddsub_mc
// Multi-channel two's-complement fixed-point adder/subtractor.
// Each channel captures its A and B operands on its own. A channel becomes
// ready once both operands are held. A round-robin arbiter issues one ready
// channel per cycle into a shared add/sub datapath. The datapath supports
// optional saturation and reports overflow.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   a/a_en/a_ch                 operand A capture into channel a_ch
//   b/b_en/b_ch/op_sub/sat_en   operand B and mode capture into channel b_ch
//   c/c_valid/c_ch/c_ovf        registered result, one-cycle valid pulse
//   a_ovr/b_ovr                 pulse: an unconsumed operand was overwritten
module fxp_qaddsub_mc #(
    parameter int W    = 64,
    parameter int FRAC = 49,
    parameter int CH   = 4,
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   a,
    input  logic           a_en,
    input  logic [CHW-1:0] a_ch,
    input  logic [W-1:0]   b,
    input  logic           b_en,
    input  logic [CHW-1:0] b_ch,
    input  logic           op_sub,
    input  logic           sat_en,
    output logic [W-1:0]   c,
    output logic           c_valid,
    output logic [CHW-1:0] c_ch,
    output logic           c_ovf,
    output logic           a_ovr,
    output logic           b_ovr
);

    // FRAC only describes the number format; the datapath ignores it.
    if (FRAC < 0 || FRAC >= W) begin : g_frac_range_error
        $error("fxp_qaddsub_mc: FRAC must lie in [0, W-1]");
    end

    logic [W-1:0]   a_hold [CH];
    logic [W-1:0]   b_hold [CH];
    logic [CH-1:0]  sub_hold;
    logic [CH-1:0]  sat_hold;
    logic [CH-1:0]  a_pend;
    logic [CH-1:0]  b_pend;
    logic [CH-1:0]  ready;
    logic [CHW-1:0] rr_ptr;
    logic [CHW-1:0] rr_next;

    logic           issue;
    logic [CHW-1:0] grant;
    int unsigned    idx;

    logic           a_hit;
    logic           b_hit;

    logic [W:0]     ext_a;
    logic [W:0]     ext_b;
    logic [W:0]     ext_sum;
    logic           ovf;
    logic [W-1:0]   result;

    assign ready = a_pend & b_pend;

    // Out-of-range channel numbers are dropped. The 32-bit cast keeps the
    // comparison meaningful when CH is not a power of two.
    assign a_hit = a_en && (32'(a_ch) < CH);
    assign b_hit = b_en && (32'(b_ch) < CH);

    // Round-robin search that starts at rr_ptr and wraps around.
    always_comb begin
        issue = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned off = 0; off < CH; off++) begin
            idx = (32'(rr_ptr) + off) % CH;
            if (!issue && ready[CHW'(idx)]) begin
                issue = 1'b1;
                grant = CHW'(idx);
            end
        end
    end

    assign rr_next = (grant == CHW'(CH - 1)) ? '0 : grant + 1'b1;

    // Shared datapath on the granted channel's held operands.
    always_comb begin
        ext_a   = {a_hold[grant][W-1], a_hold[grant]};
        ext_b   = {b_hold[grant][W-1], b_hold[grant]};
        ext_sum = sub_hold[grant] ? (ext_a - ext_b) : (ext_a + ext_b);
        ovf     = ext_sum[W] ^ ext_sum[W-1];
        result  = ext_sum[W-1:0];
        if (ovf && sat_hold[grant]) begin
            // The extra top bit holds the true sign of the result.
            result = ext_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < CH; i++) begin
                a_hold[i] <= '0;
                b_hold[i] <= '0;
            end
            sub_hold <= '0;
            sat_hold <= '0;
            a_pend   <= '0;
            b_pend   <= '0;
            rr_ptr   <= '0;
            c        <= '0;
            c_valid  <= 1'b0;
            c_ch     <= '0;
            c_ovf    <= 1'b0;
            a_ovr    <= 1'b0;
            b_ovr    <= 1'b0;
        end else begin
            c_valid <= issue;
            a_ovr   <= 1'b0;
            b_ovr   <= 1'b0;

            if (issue) begin
                c              <= result;
                c_ch           <= grant;
                c_ovf          <= ovf;
                a_pend[grant]  <= 1'b0;
                b_pend[grant]  <= 1'b0;
                rr_ptr         <= rr_next;
            end

            // A capture comes after the issue clear, so an operand that
            // arrives on the same edge as its channel issues stays pending.
            // It forms the next operation and does not count as an overwrite.
            if (a_hit) begin
                a_hold[a_ch] <= a;
                a_pend[a_ch] <= 1'b1;
                a_ovr        <= a_pend[a_ch] && !(issue && grant == a_ch);
            end

            if (b_hit) begin
                b_hold[b_ch]   <= b;
                sub_hold[b_ch] <= op_sub;
                sat_hold[b_ch] <= sat_en;
                b_pend[b_ch]   <= 1'b1;
                b_ovr          <= b_pend[b_ch] && !(issue && grant == b_ch);
            end
        end
    end

endmodule

// File: doc/fxp_qaddsub_mc.md
Name: fxp_qaddsub_mc

Overview:
- Multi-channel two's-complement fixed-point adder/subtractor. Generalises the single-channel enable/valid Q-format adder.
- Each of CH channels holds independently captured A and B operands. When both are present, the channel is ready; a round-robin arbiter issues one ready channel per cycle into a shared add/sub datapath.
- Adds per-operation subtract mode, saturate-or-wrap overflow handling, overflow flag and operand-overwrite reporting.

Parameters:
W, 64, total operand/result width (integer + fractional bits, sign included)
FRAC, 49, fractional bits; documentation and bench scaling only, datapath is format-agnostic
CH, 4, number of channels (>=1)
CHW, max(1,$clog2(CH)), channel index width (derived localparam)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
a  in  W  operand A
a_en  in  1  capture a into channel a_ch
a_ch  in  CHW  target channel for a
b  in  W  operand B
b_en  in  1  capture b, op_sub, sat_en into channel b_ch
b_ch  in  CHW  target channel for b
op_sub  in  1  1: c=a-b, 0: c=a+b (captured with b)
sat_en  in  1  1: saturate on overflow, 0: wrap (captured with b)
c  out  W  result
c_valid  out  1  one-cycle pulse per result
c_ch  out  CHW  channel of c
c_ovf  out  1  overflow detected for this result (qualified by c_valid)
a_ovr  out  1  one-cycle pulse: a_en overwrote an unconsumed A
b_ovr  out  1  one-cycle pulse: b_en overwrote an unconsumed B

Behaviour:
- Reset (rst low, async): all a_pend/b_pend cleared; held operands and modes cleared to 0; c=0, c_valid=0, c_ch=0, c_ovf=0, a_ovr=0, b_ovr=0; rr_ptr=0. Pending operands are discarded and no c_valid is produced for them.
- Capture at edge E: a_en with a_ch<CH loads A[a_ch] and sets a_pend[a_ch]. b_en likewise loads B, op_sub and sat_en and sets b_pend. An a_ch or b_ch >= CH is ignored, with no state change and no pulse.
- Overwrite: an enable that hits a channel whose pend is already set replaces the value. The matching *_ovr pulses high for the cycle after E.
- Ready: ready[i] = a_pend[i] & b_pend[i] (registered state).
- Arbitration: combinational over ready, searching from rr_ptr upward with wrap. At the edge after ready is set, the grant g is issued:
  - result registered;
  - c_valid=1, c_ch=g;
  - a_pend[g] and b_pend[g] cleared;
  - rr_ptr=(g+1) mod CH.
  With no ready channel, c_valid=0 and c, c_ch and c_ovf hold.
- Latency: last operand sampled at edge E leads to a result at edge E+1 if uncontended. With k ready channels, the k results arrive on k consecutive edges.
- Simultaneous issue and capture, same channel, same edge: the issue uses the old held values. The new operand is stored with its pend left set (not cleared) and forms the next operation. No *_ovr pulse.
- Arithmetic: W+1-bit sign-extended a±b.
  - ovf = bit W XOR bit W-1 of the extended result.
  - ovf=0: c = low W bits.
  - ovf=1, sat_en=1: c = 0x7F..F if the extended result is positive, 0x80..0 if negative.
  - ovf=1, sat_en=0: c = low W bits (wrap).
  - c_ovf=ovf in both modes.
- No backpressure: output is a valid-only interface; the consumer must accept every pulse.

Test Plan:
- Single add: W=64, FRAC=49, CH=4. ch0 a=0x0003_0000_0000_0000 (1.5), b=0x0004_8000_0000_0000 (2.25), both enabled at edge E → at edge E+1, c_valid=1, c=0x0007_8000_0000_0000 (3.75), c_ch=0, c_ovf=0. One pulse only.
- Subtract: ch1, same a and b, op_sub=1 → c=0xFFFE_8000_0000_0000 (-0.75), c_ch=1, c_ovf=0.
- Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, op_sub=0. sat_en=1 → c=0x7FFF_FFFF_FFFF_FFFF, c_ovf=1. sat_en=0 → c=0x8000_0000_0000_0000, c_ovf=1. Also a=0x8000..0, b=0x1, op_sub=1, sat_en=1 → c=0x8000_0000_0000_0000, c_ovf=1.
- Out-of-order and contention:
  - ch2 A at edge k, ch2 B at edge k+3 → single result at edge k+4, c_ch=2.
  - ch0 and ch3 both ready at edge E with rr_ptr=0 → ch0 result at E+1, ch3 at E+2, then rr_ptr=0.
  - Repeat with rr_ptr=1 → ch3 first, then ch0.
- Overwrite: ch0 a=5 at edge E, a=7 at E+1 → a_ovr high after E+1. Then b=1 → c=8.
- Overwrite during issue: a_en on the channel being issued at that same edge → no a_ovr, and the second result uses the new A.
- Reset mid-operation: ch1 A captured, rst low for 2 cycles then released. ch1 B supplied → no c_valid. Then ch1 A supplied → c_valid with the new A+B. Check all outputs are 0 during reset.
